// File: rtl/bist_apb_master.sv
// APB master that runs one BIST register read or write per command.
// Define BIST_APB_TIMEOUT_EN to abort ACCESS after TimeoutCycles cycles without pready_i.
module bist_apb_master #(
    parameter int TimeoutCycles = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_timeout_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        done;
    logic        expired;
    logic        abort;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        write_q;

    if (TimeoutCycles < 1 || TimeoutCycles > 255) begin : g_bad_timeout
        $error("TimeoutCycles must be in 1..255");
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        done        = 1'b0;
        abort       = 1'b0;
        cmd_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = ~rst_i;
                if (cmd_valid_i && !rst_i) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel_o     = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                // A ready arriving on the expiry cycle still counts as a normal completion.
                if (pready_i) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (expired) begin
                    abort      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr_i;
                write_q <= cmd_write_i;
                wdata_q <= cmd_write_i ? cmd_wdata_i : 32'd0;
            end
            if (done) begin
                rdata_q <= write_q ? 32'd0 : prdata_i;
            end else if (abort) begin
                rdata_q <= 32'd0;
            end
        end
    end

`ifdef BIST_APB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_q;

    assign expired = (wait_cnt == 8'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= 8'd0;
            end else if (state == ACCESS && !pready_i) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (done) begin
                timeout_q <= 1'b0;
            end else if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign rsp_timeout_o = timeout_q;
`else
    assign expired       = 1'b0;
    assign rsp_timeout_o = 1'b0;
`endif

    assign paddr_o     = {addr_q[31:2], 2'b00};
    assign pwrite_o    = write_q;
    assign pwdata_o    = wdata_q;
    assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_bist_apb_master.sv
// Directed bench for bist_apb_master: one task per scenario, outputs sampled on the falling edge.
module tb_bist_apb_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i = '0;
    logic        pready_i = 1'b0;

    int total = 0;
    int bad = 0;

    bist_apb_master #(.TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
    );

    always #5 clk_i = ~clk_i;

    // Issues one command from IDLE and plays the completer; lat counts falling edges after the
    // accepting edge until rsp_valid_o is seen (-1 if it never came). Returns at the RESP sample.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] rd,
                           output int lat, output logic phase_ok, output logic stable_ok);
        logic [31:0] ea;
        logic [31:0] ed;
        int acc;
        ea = {a[31:2], 2'b00};
        ed = w ? d : 32'd0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        prdata_i    = 32'h5555_5555;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 32'hFFFF_FFFF;
        cmd_wdata_i = 32'hFFFF_FFFF;
        cmd_write_i = ~w;
        lat = -1;
        phase_ok = 1'b1;
        stable_ok = 1'b1;
        acc = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk_i);
            if (k == 1 && !(psel_o && !penable_o)) phase_ok = 1'b0;
            if (k == 2 && !(psel_o && penable_o)) phase_ok = 1'b0;
            if (psel_o && (paddr_o !== ea || pwrite_o !== w || pwdata_o !== ed)) stable_ok = 1'b0;
            if (rsp_valid_o) begin
                lat = k;
                pready_i = 1'b0;
            end else if (psel_o && penable_o) begin
                acc++;
                pready_i = (acc > waits);
                prdata_i = pready_i ? rd : 32'h5555_5555;
            end else begin
                pready_i = (k == 1 && waits == 0);
                prdata_i = 32'h5555_5555;
            end
        end
        pready_i = 1'b0;
        cmd_write_i = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_i);
        total++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0 || paddr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got psel=%b pen=%b rsp=%b paddr=%h need all 0",
                     psel_o, penable_o, rsp_valid_o, paddr_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (cmd_ready_o !== 1'b1 || rsp_timeout_o !== 1'b0 || rsp_rdata_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_release got ready=%b to=%b rdata=%h need 1 0 0",
                     cmd_ready_o, rsp_timeout_o, rsp_rdata_o);
        end
    endtask

    task automatic test_read_wait;
        int lat;
        logic ph, st;
        do_xfer(1'b0, 32'h0000_0008, 32'h7777_7777, 3, 32'h0000_00A5, lat, ph, st);
        total++;
        if (lat !== 6) begin bad++; $display("FAIL read_wait_latency got %0d need 6", lat); end
        total++;
        if (rsp_rdata_o !== 32'h0000_00A5) begin
            bad++; $display("FAIL read_wait_rdata got %h need 000000a5", rsp_rdata_o);
        end
        total++;
        if (ph !== 1'b1 || st !== 1'b1) begin
            bad++; $display("FAIL read_wait_apb got phase=%b stable=%b need 1 1", ph, st);
        end
        @(negedge clk_i);
        total++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++; $display("FAIL read_wait_pulse got rsp=%b ready=%b need 0 1", rsp_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_write;
        int lat;
        logic ph, st;
        do_xfer(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 32'h0000_0000, lat, ph, st);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL write_latency got %0d need 3", lat); end
        total++;
        if (rsp_rdata_o !== 32'd0 || rsp_timeout_o !== 1'b0) begin
            bad++; $display("FAIL write_rsp got rdata=%h to=%b need 0 0", rsp_rdata_o, rsp_timeout_o);
        end
        total++;
        if (ph !== 1'b1 || st !== 1'b1) begin
            bad++; $display("FAIL write_apb got phase=%b stable=%b need 1 1", ph, st);
        end
    endtask

    task automatic test_addr_align;
        int lat;
        logic ph, st;
        do_xfer(1'b0, 32'h0000_000B, 32'h0, 1, 32'h1234_5678, lat, ph, st);
        total++;
        if (st !== 1'b1 || lat !== 4) begin
            bad++; $display("FAIL addr_align got stable=%b lat=%0d need 1 4", st, lat);
        end
        total++;
        if (paddr_o !== 32'h0000_0008) begin
            bad++; $display("FAIL addr_align_paddr got %h need 00000008", paddr_o);
        end
        repeat (3) @(negedge clk_i);
        total++;
        if (rsp_rdata_o !== 32'h1234_5678) begin
            bad++; $display("FAIL rdata_hold got %h need 12345678", rsp_rdata_o);
        end
    endtask

    task automatic test_timeout;
        int lat;
        logic ph, st;
`ifdef BIST_APB_TIMEOUT_EN
        do_xfer(1'b0, 32'h0000_0010, 32'h0, 1000, 32'h0, lat, ph, st);
        total++;
        if (lat !== 18 || rsp_timeout_o !== 1'b1 || rsp_rdata_o !== 32'd0) begin
            bad++; $display("FAIL timeout_abort got lat=%0d to=%b rdata=%h need 18 1 0",
                            lat, rsp_timeout_o, rsp_rdata_o);
        end
        do_xfer(1'b0, 32'h0000_0014, 32'h0, 15, 32'h0000_0C3C, lat, ph, st);
        total++;
        if (lat !== 18 || rsp_timeout_o !== 1'b0 || rsp_rdata_o !== 32'h0000_0C3C) begin
            bad++; $display("FAIL timeout_edge got lat=%0d to=%b rdata=%h need 18 0 00000c3c",
                            lat, rsp_timeout_o, rsp_rdata_o);
        end
`else
        do_xfer(1'b0, 32'h0000_0010, 32'h0, 25, 32'h0000_0C3C, lat, ph, st);
        total++;
        if (lat !== 28 || rsp_timeout_o !== 1'b0 || rsp_rdata_o !== 32'h0000_0C3C) begin
            bad++; $display("FAIL no_timeout got lat=%0d to=%b rdata=%h need 28 0 00000c3c",
                            lat, rsp_timeout_o, rsp_rdata_o);
        end
`endif
        do_xfer(1'b1, 32'h0000_0018, 32'hA5A5_0001, 0, 32'h0, lat, ph, st);
        total++;
        if (lat !== 3 || rsp_timeout_o !== 1'b0 || ph !== 1'b1) begin
            bad++; $display("FAIL after_timeout got lat=%0d to=%b phase=%b need 3 0 1",
                            lat, rsp_timeout_o, ph);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h0000_0030;
        pready_i    = 1'b0;
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
            bad++; $display("FAIL mid_in_access got psel=%b pen=%b need 1 1", psel_o, penable_o);
        end
        #2 rst_i = 1'b1;
        #1;
        total++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            bad++; $display("FAIL mid_async_drop got psel=%b pen=%b rsp=%b need 0 0 0",
                            psel_o, penable_o, rsp_valid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++;
        if (cmd_ready_o !== 1'b1) begin
            bad++; $display("FAIL mid_ready_after got %b need 1", cmd_ready_o);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (rsp_valid_o || psel_o) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL mid_no_rsp got %0d need 0", pulses); end
    endtask

    task automatic test_back_to_back;
        int nacc, nsetup, first_rsp, second_acc;
        logic [31:0] setup2_addr;
        nacc = 0; nsetup = 0; first_rsp = -1; second_acc = -1; setup2_addr = '0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_addr_i  = 32'h0000_0020;
        cmd_wdata_i = 32'h0000_0011;
        pready_i    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk_i);
            if (psel_o && !penable_o) begin
                nsetup++;
                if (nsetup == 2) setup2_addr = paddr_o;
            end
            if (rsp_valid_o && first_rsp < 0) first_rsp = k;
            if (cmd_valid_i && cmd_ready_o) begin
                nacc++;
                if (nacc == 2) second_acc = k;
            end
            if (k == 1) begin
                cmd_addr_i  = 32'h0000_0024;
                cmd_wdata_i = 32'h0000_0022;
            end
            if (second_acc >= 0 && k == second_acc + 1) cmd_valid_i = 1'b0;
        end
        pready_i = 1'b0;
        cmd_valid_i = 1'b0;
        total++;
        if (first_rsp !== 3 || second_acc !== 4) begin
            bad++; $display("FAIL b2b_order got rsp=%0d acc2=%0d need 3 4", first_rsp, second_acc);
        end
        total++;
        if (nsetup !== 2 || nacc !== 2) begin
            bad++; $display("FAIL b2b_count got setups=%0d accepts=%0d need 2 2", nsetup, nacc);
        end
        total++;
        if (setup2_addr !== 32'h0000_0024) begin
            bad++; $display("FAIL b2b_addr2 got %h need 00000024", setup2_addr);
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_addr_align();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
